// File: rtl/pi_io_seq_pkg.sv
// Shared types and widths for the PI single-word I/O sequencer.
package pi_io_seq_pkg;

   localparam int PBUS_AD_SIZE   = 16;
   localparam int DOM_LAT_W      = 8;
   localparam int DOM_PULSE_W    = 8;
   localparam int DOM_REL_W      = 4;
   localparam int CNT_W          = 8;
   localparam int ADDR_SETUP_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR_HI = 3'd1,
      ST_ADDR_LO = 3'd2,
      ST_LATENCY = 3'd3,
      ST_PULSE   = 3'd4,
      ST_RELEASE = 3'd5
   } pi_state_t;

   // The bus is halfword addressed, so the low address halfword never carries bit 0.
   function automatic logic [PBUS_AD_SIZE-1:0] lo_addr_hw(input logic [PBUS_AD_SIZE-1:0] a);
      return a & 16'hFFFE;
   endfunction

endpackage

// File: rtl/pi_io_seq_if.sv
// Request/response channel between the cbus decode logic and the I/O sequencer.
interface pi_io_seq_if;
   import pi_io_seq_pkg::*;

   logic                   start;
   logic                   write;
   logic [31:0]            address;
   logic [31:0]            write_data;
   logic [DOM_LAT_W-1:0]   dom_latency;
   logic [DOM_PULSE_W-1:0] dom_pulse;
   logic [DOM_REL_W-1:0]   dom_release;
   logic                   busy;
   logic [31:0]            read_data;

   modport master (
      output start, write, address, write_data, dom_latency, dom_pulse, dom_release,
      input  busy, read_data
   );

   modport slave (
      input  start, write, address, write_data, dom_latency, dom_pulse, dom_release,
      output busy, read_data
   );

endinterface

// File: rtl/pi_dom_timer.sv
// Loadable 8-bit down-counter that times each PBUS phase; load wins over enable.
module pi_dom_timer
   import pi_io_seq_pkg::*;
(
   input  logic             clock,
   input  logic             reset_l,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pi_io_seq.sv
// Sequences one 32-bit PI I/O cycle as two halfword strobes on the multiplexed PBUS.
//
// state      | meaning
// IDLE       | waiting for io_start; pins at rest
// ADDR_HI    | ale_h/ale_l high, upper address halfword on AD
// ADDR_LO    | ale_l high, lower address halfword on AD
// LATENCY    | device access latency; write data pre-driven
// PULSE      | read or write strobe low for the current halfword
// RELEASE    | strobes high; loops to PULSE once for the lower halfword
module pi_io_seq
   import pi_io_seq_pkg::*;
#(
   parameter int ADDR_SETUP = ADDR_SETUP_DEF
) (
   input  logic                    clock,
   input  logic                    reset_l,
   pi_io_seq_if.slave              io_if,
   output logic [PBUS_AD_SIZE-1:0] pbus_ad_out_o,
   output logic                    pbus_ad_oe_o,
   input  logic [PBUS_AD_SIZE-1:0] pbus_ad_in_i,
   output logic                    pbus_ale_h_o,
   output logic                    pbus_ale_l_o,
   output logic                    pbus_read_l_o,
   output logic                    pbus_write_l_o
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(ADDR_SETUP - 1);

   pi_state_t              state_q, state_d;
   logic                   hw_q, hw_d, wr_q, wr_d;
   logic [31:0]            addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
   logic [DOM_LAT_W-1:0]   lat_q, lat_d;
   logic [DOM_PULSE_W-1:0] pulse_q, pulse_d;
   logic [DOM_REL_W-1:0]   rel_q, rel_d;
   logic                   busy_q, busy_d, ale_h_q, ale_h_d, ale_l_q, ale_l_d;
   logic                   rd_l_q, rd_l_d, wr_l_q, wr_l_d, oe_q, oe_d;
   logic [PBUS_AD_SIZE-1:0] ad_q, ad_d, cur_hw;
   logic                   tmr_load, tmr_en, tmr_zero;
   logic [CNT_W-1:0]       tmr_val;

   pi_dom_timer u_timer (
      .clock      (clock),
      .reset_l    (reset_l),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   always_comb begin : next_state
      state_d  = state_q;
      hw_d     = hw_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rdata_d  = rdata_q;
      lat_d    = lat_q;
      pulse_d  = pulse_q;
      rel_d    = rel_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
      case (state_q)
         ST_IDLE: if (io_if.start) begin
            wr_d     = io_if.write;
            addr_d   = io_if.address;
            data_d   = io_if.write_data;
            lat_d    = io_if.dom_latency;
            pulse_d  = io_if.dom_pulse;
            rel_d    = io_if.dom_release;
            hw_d     = 1'b0;
            state_d  = ST_ADDR_HI;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
         end
         ST_ADDR_HI: if (tmr_zero) begin
            state_d  = ST_ADDR_LO;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
         end else tmr_en = 1'b1;
         ST_ADDR_LO: if (tmr_zero) begin
            state_d  = ST_LATENCY;
            tmr_load = 1'b1;
            tmr_val  = lat_q;
         end else tmr_en = 1'b1;
         ST_LATENCY: if (tmr_zero) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = pulse_q;
         end else tmr_en = 1'b1;
         ST_PULSE: if (tmr_zero) begin
            if (!wr_q) begin
               if (hw_q) data_d[15:0]  = pbus_ad_in_i;
               else      data_d[31:16] = pbus_ad_in_i;
            end
            state_d  = ST_RELEASE;
            tmr_load = 1'b1;
            tmr_val  = {4'b0, rel_q};
         end else tmr_en = 1'b1;
         ST_RELEASE: if (tmr_zero) begin
            if (!hw_q) begin
               // Device auto-increments, so the lower halfword needs no new address phase.
               hw_d     = 1'b1;
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = pulse_q;
            end else begin
               state_d = ST_IDLE;
               if (!wr_q) rdata_d = data_q;
            end
         end else tmr_en = 1'b1;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so every output leaves a flop.
   always_comb begin : out_dec
      cur_hw  = hw_d ? data_d[15:0] : data_d[31:16];
      busy_d  = (state_d != ST_IDLE);
      ale_h_d = 1'b0;
      ale_l_d = 1'b0;
      rd_l_d  = 1'b1;
      wr_l_d  = 1'b1;
      oe_d    = 1'b0;
      ad_d    = '0;
      case (state_d)
         ST_ADDR_HI: begin
            ale_h_d = 1'b1;
            ale_l_d = 1'b1;
            oe_d    = 1'b1;
            ad_d    = addr_d[31:16];
         end
         ST_ADDR_LO: begin
            ale_l_d = 1'b1;
            oe_d    = 1'b1;
            ad_d    = lo_addr_hw(addr_d[15:0]);
         end
         ST_LATENCY: if (wr_d) begin
            oe_d = 1'b1;
            ad_d = data_d[31:16];
         end
         ST_PULSE: if (wr_d) begin
            wr_l_d = 1'b0;
            oe_d   = 1'b1;
            ad_d   = cur_hw;
         end else rd_l_d = 1'b0;
         ST_RELEASE: if (wr_d) begin
            oe_d = 1'b1;
            ad_d = cur_hw;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= ST_IDLE;
         hw_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         lat_q   <= '0;
         pulse_q <= '0;
         rel_q   <= '0;
         busy_q  <= 1'b0;
         ale_h_q <= 1'b0;
         ale_l_q <= 1'b0;
         rd_l_q  <= 1'b1;
         wr_l_q  <= 1'b1;
         oe_q    <= 1'b0;
         ad_q    <= '0;
      end else begin
         state_q <= state_d;
         hw_q    <= hw_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         lat_q   <= lat_d;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
         busy_q  <= busy_d;
         ale_h_q <= ale_h_d;
         ale_l_q <= ale_l_d;
         rd_l_q  <= rd_l_d;
         wr_l_q  <= wr_l_d;
         oe_q    <= oe_d;
         ad_q    <= ad_d;
      end
   end

   assign io_if.busy      = busy_q;
   assign io_if.read_data = rdata_q;
   assign pbus_ad_out_o   = ad_q;
   assign pbus_ad_oe_o    = oe_q;
   assign pbus_ale_h_o    = ale_h_q;
   assign pbus_ale_l_o    = ale_l_q;
   assign pbus_read_l_o   = rd_l_q;
   assign pbus_write_l_o  = wr_l_q;

endmodule

// File: tb/tb_pi_io_seq.sv
// Directed and randomized checks of pi_io_seq against a cycle-count / bus-trace reference model.
module tb_pi_io_seq;
   localparam int AS = 4;

   logic        clock = 1'b0;
   logic        reset_l = 1'b0;
   logic [15:0] ad_out, ad_in;
   logic        oe, ale_h, ale_l, rd_l, wr_l;

   pi_io_seq_if dif();

   pi_io_seq #(.ADDR_SETUP(AS)) dut (
      .clock          (clock),
      .reset_l        (reset_l),
      .io_if          (dif),
      .pbus_ad_out_o  (ad_out),
      .pbus_ad_oe_o   (oe),
      .pbus_ad_in_i   (ad_in),
      .pbus_ale_h_o   (ale_h),
      .pbus_ale_l_o   (ale_l),
      .pbus_read_l_o  (rd_l),
      .pbus_write_l_o (wr_l)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference expectations, set before each op.
   logic        exp_wr = 1'b0;
   logic [15:0] exp_ahi = '0, exp_alo = '0, dev_hi = '0, dev_lo = '0;
   logic [31:0] exp_wd = '0;

   // Bus monitor and device model.
   int   cyc, busy_n, ahi_n, alo_n, ad_bad, oe_low, cur_wl, cur_rl;
   int   viol = 0;
   int   rd_done = 0;
   int   wl_len[$], wl_start[$], rl_len[$];
   logic prev_busy = 1'b0, prev_rd = 1'b1;

   always @(negedge clock) begin
      if (dif.busy && !prev_busy) begin
         cyc = 0; busy_n = 0; ahi_n = 0; alo_n = 0; ad_bad = 0; oe_low = 0;
         cur_wl = 0; cur_rl = 0;
         wl_len.delete(); wl_start.delete(); rl_len.delete();
      end
      if (dif.busy) begin
         busy_n++;
         if (ale_h) begin
            ahi_n++;
            if (ad_out !== exp_ahi) ad_bad++;
         end else if (ale_l) begin
            alo_n++;
            if (ad_out !== exp_alo) ad_bad++;
         end
         if (!wr_l) begin
            if (cur_wl == 0) wl_start.push_back(cyc);
            cur_wl++;
            if (ad_out !== ((wl_len.size() == 0) ? exp_wd[31:16] : exp_wd[15:0])) ad_bad++;
         end else if (cur_wl != 0) begin
            wl_len.push_back(cur_wl);
            cur_wl = 0;
         end
         if (!rd_l) cur_rl++;
         else if (cur_rl != 0) begin
            rl_len.push_back(cur_rl);
            cur_rl = 0;
         end
         if (exp_wr && !oe) oe_low++;
         cyc++;
      end
      if (!rd_l && !wr_l) viol++;
      if (!rd_l && oe) viol++;
      if (!prev_rd && rd_l) rd_done++;
      if (!dif.busy) rd_done = 0;
      prev_rd   = rd_l;
      prev_busy = dif.busy;
      ad_in     = (rd_done == 0) ? dev_hi : dev_lo;
   end

   function automatic int exp_busy(input int lat, input int pul, input int rel);
      return 2 * AS + (lat + 1) + 2 * (pul + 1) + 2 * (rel + 1);
   endfunction

   task automatic set_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input int pul, input int rel);
      exp_wr  = wr;
      exp_ahi = addr[31:16];
      exp_alo = {addr[15:1], 1'b0};
      exp_wd  = data;
      dif.start       = 1'b1;
      dif.write       = wr;
      dif.address     = addr;
      dif.write_data  = data;
      dif.dom_latency = 8'(lat);
      dif.dom_pulse   = 8'(pul);
      dif.dom_release = 4'(rel);
   endtask

   task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int lat, input int pul, input int rel, input bit hold);
      logic [31:0] rd_before;
      int n;
      rd_before = dif.read_data;
      set_req(wr, addr, data, lat, pul, rel);
      @(negedge clock);
      #1;
      if (!hold) dif.start = 1'b0;
      // Sampled fields must be ignored once the op is running.
      dif.write       = ~wr;
      dif.address     = $urandom;
      dif.write_data  = $urandom;
      dif.dom_latency = 8'($urandom);
      dif.dom_pulse   = 8'($urandom);
      dif.dom_release = 4'($urandom);
      n = 0;
      while (dif.busy && n < 3000) begin
         @(negedge clock);
         #1;
         n++;
      end
      dif.start = 1'b0;
      chk("busy_done_in_time", 32'(n < 3000), 32'd1);
      chk("busy_cycles", busy_n, exp_busy(lat, pul, rel));
      chk("ale_h_cycles", ahi_n, AS);
      chk("ale_l_only_cycles", alo_n, AS);
      chk("ad_value_errs", ad_bad, 0);
      chk("strobe_oe_viol", viol, 0);
      if (wr) begin
         chk("wr_strobe_runs", wl_len.size(), 2);
         chk("rd_strobe_runs_on_wr", rl_len.size(), 0);
         if (wl_len.size() == 2) begin
            chk("wr_pulse0_len", wl_len[0], pul + 1);
            chk("wr_pulse1_len", wl_len[1], pul + 1);
            chk("wr_gap_len", wl_start[1] - (wl_start[0] + wl_len[0]), rel + 1);
         end
         chk("wr_oe_low_cycles", oe_low, 0);
         chk("rdata_kept_on_wr", dif.read_data, rd_before);
      end else begin
         chk("rd_strobe_runs", rl_len.size(), 2);
         chk("wr_strobe_runs_on_rd", wl_len.size(), 0);
         if (rl_len.size() == 2) begin
            chk("rd_pulse0_len", rl_len[0], pul + 1);
            chk("rd_pulse1_len", rl_len[1], pul + 1);
         end
         chk("read_data", dif.read_data, {dev_hi, dev_lo});
      end
   endtask

   initial begin
      int n;
      dif.start = 1'b0; dif.write = 1'b0; dif.address = '0; dif.write_data = '0;
      dif.dom_latency = '0; dif.dom_pulse = '0; dif.dom_release = '0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_busy", dif.busy, 0);
      chk("rst_ale_h", ale_h, 0);
      chk("rst_ale_l", ale_l, 0);
      chk("rst_read_l", rd_l, 1);
      chk("rst_write_l", wr_l, 1);
      chk("rst_oe", oe, 0);
      chk("rst_ad", ad_out, 0);
      chk("rst_rdata", dif.read_data, 0);
      reset_l = 1'b1;
      @(negedge clock);
      #1;

      dev_hi = 16'hABCD; dev_lo = 16'h1234;
      do_op(1'b0, 32'h1000_0004, 32'h0, 0, 0, 0, 1'b0);
      @(negedge clock); #1;
      do_op(1'b1, 32'h1000_0100, 32'hDEAD_BEEF, 3, 5, 2, 1'b0);
      @(negedge clock); #1;

      // io_start held high for the whole read: exactly one op.
      dev_hi = 16'h5A5A; dev_lo = 16'hC3C3;
      do_op(1'b0, 32'h0800_1230, 32'h0, 1, 2, 1, 1'b1);
      repeat (3) @(negedge clock);
      #1;
      chk("held_start_single_op", dif.busy, 0);

      // Back-to-back: start in the first idle cycle.
      dev_hi = 16'h1111; dev_lo = 16'h2222;
      do_op(1'b0, 32'h0500_0003, 32'h0, 0, 1, 0, 1'b0);
      dev_hi = 16'h3333; dev_lo = 16'h4444;
      do_op(1'b0, 32'h0500_0102, 32'h0, 2, 0, 1, 1'b0);
      @(negedge clock); #1;

      for (int i = 0; i < 10; i++) begin
         dev_hi = 16'($urandom); dev_lo = 16'($urandom);
         do_op(1'($urandom), $urandom, $urandom, $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 1) == 1) begin @(negedge clock); #1; end
      end

      dev_hi = 16'hF00D; dev_lo = 16'h0FF1;
      do_op(1'b0, 32'h1FFF_FFFE, 32'h0, 255, 255, 15, 1'b0);
      @(negedge clock); #1;

      // Reset during the second read strobe.
      dev_hi = 16'h7777; dev_lo = 16'h8888;
      set_req(1'b0, 32'h1000_0040, 32'h0, 1, 3, 1);
      @(negedge clock); #1;
      dif.start = 1'b0;
      n = 0;
      while (!(rd_done == 1 && !rd_l) && n < 3000) begin
         @(negedge clock); #1;
         n++;
      end
      chk("reached_second_pulse", 32'(n < 3000), 32'd1);
      reset_l = 1'b0;
      #2;
      chk("midrst_busy", dif.busy, 0);
      chk("midrst_read_l", rd_l, 1);
      chk("midrst_ale_h", ale_h, 0);
      chk("midrst_ale_l", ale_l, 0);
      chk("midrst_oe", oe, 0);
      chk("midrst_rdata", dif.read_data, 0);
      @(negedge clock); #1;
      reset_l = 1'b1;
      @(negedge clock); #1;
      chk("post_rst_idle", dif.busy, 0);

      dev_hi = 16'hCAFE; dev_lo = 16'hBABE;
      do_op(1'b0, 32'h0600_0010, 32'h0, 0, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
